// File: rtl/matrix_image_loader.sv
// Stream-to-SRAM loader for the attention engine: writes the input and
// weight images with size headers, then launches the engine and waits.
module matrix_image_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              input_we,
  output logic [ADDR_W-1:0] input_waddr,
  output logic [DATA_W-1:0] input_wdata,
  output logic              weight_we,
  output logic [ADDR_W-1:0] weight_waddr,
  output logic [DATA_W-1:0] weight_wdata,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, A_HDR, A_CHK, A_DATA,
    W_HDR, W_CHK, W_DATA,
    LAUNCH, WAIT_DONE
  } state_t;

  state_t state;

  logic [15:0] rows_a, cols_a;
  logic [15:0] rows_w, cols_w;
  logic [ADDR_W-1:0] k, k_last;
  logic [31:0] n_a, n_w;
  logic [34:0] lim, n_a1, n_w31;
  logic acc, bad_a, bad_w;

  assign acc   = s_valid && s_ready;
  assign n_a   = 32'(rows_a) * 32'(cols_a);
  assign n_w   = 32'(rows_w) * 32'(cols_w);
  assign lim   = 35'd1 << ADDR_W;
  assign n_a1  = 35'(n_a) + 35'd1;
  assign n_w31 = 35'(n_w) * 35'd3 + 35'd1;

  assign bad_a = (rows_a == 16'd0) || (cols_a == 16'd0)
              || (n_a1 > lim);
  assign bad_w = (rows_w != cols_a) || (cols_w == 16'd0)
              || (n_w31 > lim);

  // done/err are held one cycle in the reporting state, so the
  // loader only reaches IDLE after the pulse has been seen
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      s_ready      <= 1'b0;
      input_we     <= 1'b0;
      input_waddr  <= '0;
      input_wdata  <= '0;
      weight_we    <= 1'b0;
      weight_waddr <= '0;
      weight_wdata <= '0;
      dut_valid    <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      rows_a       <= '0;
      cols_a       <= '0;
      rows_w       <= '0;
      cols_w       <= '0;
      k            <= '0;
      k_last       <= '0;
    end else begin
      input_we  <= 1'b0;
      weight_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            s_ready <= 1'b1;
            state   <= A_HDR;
          end
        end
        A_HDR: begin
          if (acc) begin
            rows_a      <= s_data[31:16];
            cols_a      <= s_data[15:0];
            input_we    <= 1'b1;
            input_waddr <= '0;
            input_wdata <= s_data;
            s_ready     <= 1'b0;
            state       <= A_CHK;
          end
        end
        A_CHK: begin
          if (err) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (bad_a) begin
            err <= 1'b1;
          end else begin
            k       <= '0;
            k_last  <= ADDR_W'(n_a - 32'd1);
            s_ready <= 1'b1;
            state   <= A_DATA;
          end
        end
        A_DATA: begin
          if (acc) begin
            input_we    <= 1'b1;
            input_waddr <= k + ADDR_W'(1);
            input_wdata <= s_data;
            k           <= k + ADDR_W'(1);
            if (k == k_last) begin
              k     <= '0;
              state <= W_HDR;
            end
          end
        end
        W_HDR: begin
          if (acc) begin
            rows_w       <= s_data[31:16];
            cols_w       <= s_data[15:0];
            weight_we    <= 1'b1;
            weight_waddr <= '0;
            weight_wdata <= s_data;
            s_ready      <= 1'b0;
            state        <= W_CHK;
          end
        end
        W_CHK: begin
          if (err) begin
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (bad_w) begin
            err <= 1'b1;
          end else begin
            k       <= '0;
            k_last  <= ADDR_W'(n_w31 - 35'd2);
            s_ready <= 1'b1;
            state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (acc) begin
            weight_we    <= 1'b1;
            weight_waddr <= k + ADDR_W'(1);
            weight_wdata <= s_data;
            k            <= k + ADDR_W'(1);
            if (k == k_last) begin
              s_ready <= 1'b0;
              state   <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (!dut_valid) begin
            dut_valid <= 1'b1;
          end else if (!dut_ready) begin
            dut_valid <= 1'b0;
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (done) begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (dut_ready) begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_image_loader.sv
// Bench for matrix_image_loader: table of header cases plus reset and
// handshake sequences, checked against a stream/image model.
module tb_matrix_image_loader;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, start, s_valid, dut_ready;
  logic [DW-1:0] s_data;
  logic          busy, s_ready, input_we, weight_we;
  logic          dut_valid, done, err;
  logic [AW-1:0] input_waddr, weight_waddr;
  logic [DW-1:0] input_wdata, weight_wdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  matrix_image_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .input_we(input_we), .input_waddr(input_waddr),
    .input_wdata(input_wdata),
    .weight_we(weight_we), .weight_waddr(weight_waddr),
    .weight_wdata(weight_wdata),
    .dut_valid(dut_valid), .dut_ready(dut_ready),
    .done(done), .err(err)
  );

  typedef struct {
    int ra; int ca; int rw; int cw; int gap;
    int exp_err; int exp_in; int exp_w;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"},
        {s_ready, busy, input_we, weight_we, dut_valid, done, err}, 0);
    chk({tag, "_addr"}, {input_waddr, weight_waddr}, 0);
    chk({tag, "_data"}, {input_wdata, weight_wdata}, 0);
  endtask

  // rst_mode: 0 none, 1 reset at A k=5, 2 reset in WAIT_DONE
  task automatic run_load(input int ra, input int ca, input int rw,
                          input int cw, input int gap, input int hold,
                          input int exp_err, input int exp_in,
                          input int exp_w, input int rst_mode,
                          input bit extra_start);
    logic [31:0] strm[$];
    longint na, nw;
    bit err_a, err_w, acc_prev, fin, end_next, rst_pend;
    int nin, idx, in_cnt, w_cnt, err_cnt, done_cnt, dv_cnt;
    int eng, eng_cnt, low, rise_cyc, done_cyc, c_start, dv_first;
    int budget;

    na = longint'(ra) * longint'(ca);
    nw = longint'(rw) * longint'(cw);
    err_a = (ra == 0) || (ca == 0) || (na + 1 > 65536);
    err_w = (rw != ca) || (cw == 0) || (3 * nw + 1 > 65536);
    strm = {};
    strm.push_back({ra[15:0], ca[15:0]});
    if (!err_a) begin
      repeat (na) strm.push_back($urandom);
      strm.push_back({rw[15:0], cw[15:0]});
      if (!err_w) repeat (3 * nw) strm.push_back($urandom);
    end
    nin = err_a ? 1 : 1 + int'(na);

    idx = 0; in_cnt = 0; w_cnt = 0; err_cnt = 0; done_cnt = 0;
    dv_cnt = 0; eng = 0; eng_cnt = 0; low = 0; rise_cyc = 0;
    done_cyc = 0; dv_first = 0; budget = 0;
    fin = 0; end_next = 0; rst_pend = 0;
    dut_ready = 1'b1;
    start = 1'b1;
    c_start = cyc;
    s_valid = 1'b1;
    s_data = strm[0];

    while (!fin) begin
      acc_prev = s_valid && s_ready;
      tick();
      budget++;
      start = 1'b0;
      if (rst_pend) begin
        chk_zero("reset_mid");
        reset = 1'b0;
        dut_ready = 1'b1;
        s_valid = 1'b0;
        fin = 1;
        continue;
      end
      if (acc_prev) idx++;
      if (input_we) begin
        chk("in_we_no_accept", acc_prev, 1);
        chk("in_waddr", input_waddr, in_cnt);
        if (in_cnt < nin)
          chk("in_wdata", input_wdata, strm[in_cnt]);
        in_cnt++;
      end
      if (weight_we) begin
        chk("w_we_no_accept", acc_prev, 1);
        chk("w_waddr", weight_waddr, w_cnt);
        if (nin + w_cnt < strm.size())
          chk("w_wdata", weight_wdata, strm[nin + w_cnt]);
        w_cnt++;
      end
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (dut_valid) begin
        dv_cnt++;
        if (dv_first == 0) dv_first = cyc;
      end
      if (eng == 0) begin
        if (dut_valid) begin
          eng_cnt++;
          if (eng_cnt == hold + 1) begin
            dut_ready = 1'b0;
            eng = 1;
            low = 0;
          end
        end
      end else if (eng == 1) begin
        low++;
        if (rst_mode == 2 && low == 2) begin
          reset = 1'b1;
          rst_pend = 1;
        end
        if (low == 4) begin
          dut_ready = 1'b1;
          eng = 2;
          rise_cyc = cyc;
        end
      end
      if (rst_mode == 1 && in_cnt == 6 && !rst_pend) begin
        reset = 1'b1;
        rst_pend = 1;
      end
      if (extra_start &&
          (cyc - c_start == 20 || (dut_valid && dv_cnt == 3) || done))
        start = 1'b1;
      if (end_next) begin
        chk("busy_after_end", busy, 0);
        fin = 1;
      end else if (err || done) begin
        end_next = 1;
      end
      if (!(s_valid && !acc_prev)) begin
        if (idx < strm.size() && $urandom_range(99) >= gap) begin
          s_valid = 1'b1;
          s_data = strm[idx];
        end else begin
          s_valid = 1'b0;
          s_data = $urandom;
        end
      end
      if (budget > 5000 && !fin) begin
        tests++;
        fails++;
        $display("FAIL timeout: %0d cycles without done/err", budget);
        fin = 1;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;

    if (rst_mode == 0) begin
      chk("in_writes", in_cnt, exp_in);
      chk("w_writes", w_cnt, exp_w);
      chk("err_pulses", err_cnt, (exp_err != 0) ? 1 : 0);
      chk("done_pulses", done_cnt, (exp_err == 0) ? 1 : 0);
      chk("dv_cycles", dv_cnt, (exp_err == 0) ? hold + 1 : 0);
      if (exp_err == 0)
        chk("done_timing", done_cyc, rise_cyc + 1);
      if (exp_err == 0 && gap == 0)
        chk("load_latency", dv_first - c_start - 1,
            2 + na + 1 + 1 + 3 * nw + 1);
    end
    tick();
  endtask

  initial begin
    vt[0] = '{4, 16, 16, 16, 0, 0, 65, 769};
    vt[1] = '{2, 4, 4, 4, 30, 0, 9, 49};
    vt[2] = '{2, 4, 3, 4, 0, 2, 9, 1};
    vt[3] = '{0, 8, 1, 1, 0, 1, 1, 0};
    vt[4] = '{65535, 65535, 1, 1, 0, 1, 1, 0};
    vt[5] = '{1, 128, 128, 171, 0, 2, 129, 1};
    vt[6] = '{2, 4, 4, 0, 20, 2, 9, 1};
    vt[7] = '{3, 5, 5, 2, 50, 0, 16, 31};
    vt[8] = '{256, 256, 1, 1, 0, 1, 1, 0};

    reset = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    dut_ready = 1'b1;
    repeat (3) tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++)
      run_load(vt[i].ra, vt[i].ca, vt[i].rw, vt[i].cw, vt[i].gap, 1,
               vt[i].exp_err, vt[i].exp_in, vt[i].exp_w, 0, 1'b0);

    run_load(2, 4, 4, 4, 0, 1, 0, 0, 0, 1, 1'b0);
    run_load(2, 4, 4, 4, 0, 1, 0, 9, 49, 0, 1'b0);

    run_load(2, 4, 4, 4, 0, 5, 0, 9, 49, 0, 1'b1);

    run_load(2, 4, 4, 4, 0, 1, 0, 0, 0, 2, 1'b0);
    run_load(2, 4, 4, 4, 30, 1, 0, 9, 49, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/matrix_image_loader.md
# matrix_image_loader

Front-end loader for the attention matrix engine (`MyDesign`). It accepts a word stream and writes the input image and the weight image into their SRAMs using the layout the engine reads:
- Input SRAM: header word {rows, cols}, then A in row-major order.
- Weight SRAM: header word {rows, cols}, then Wq, Wk and Wv back-to-back, each row-major.

After both images are written, the loader launches the engine through the dut_valid/dut_ready handshake and reports completion. It is the initiator side of that handshake and the writer side of the SRAM images.

## Interface
- ADDR_W, default 16: SRAM address width; must match `SRAM_ADDR_WIDTH.
- DATA_W, default 32: SRAM data width; must be 32, because the header is {rows[31:16], cols[15:0]}.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE, ignored otherwise.
- busy  out  1  high in every state except IDLE.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid && s_ready.
- s_data  in  DATA_W  stream word (header or signed element).
- input_we  out  1  input SRAM write enable.
- input_waddr  out  ADDR_W  input SRAM write address.
- input_wdata  out  DATA_W  input SRAM write data.
- weight_we  out  1  weight SRAM write enable.
- weight_waddr  out  ADDR_W  weight SRAM write address.
- weight_wdata  out  DATA_W  weight SRAM write data.
- dut_valid  out  1  launch request to the engine.
- dut_ready  in  1  engine idle indicator (high = idle).
- done  out  1  one-cycle pulse when the engine has finished.
- err  out  1  one-cycle pulse when the loader aborts on a bad header.

## Operation
The state machine has nine states: IDLE, A_HDR, A_CHK, A_DATA, W_HDR, W_CHK, W_DATA, LAUNCH, WAIT_DONE.

- IDLE: s_ready=0, dut_valid=0. start -> A_HDR.
- A_HDR:
  - s_ready=1.
  - On accept, latch rowsA = s_data[31:16] and colsA = s_data[15:0].
  - Write the word to input address 0.
  - -> A_CHK.
- A_CHK:
  - s_ready=0; one cycle.
  - Compute nA = rowsA*colsA with a 32-bit product.
  - Error if rowsA==0, colsA==0, or nA+1 > 2^ADDR_W; on error, pulse err and go to IDLE.
  - Otherwise -> A_DATA.
- A_DATA:
  - s_ready=1; each accepted word is written to input address 1+k, for k = 0..nA-1.
  - The accept with k==nA-1 -> W_HDR.
- W_HDR:
  - s_ready=1.
  - On accept, latch rowsW and colsW.
  - Write the word to weight address 0.
  - -> W_CHK.
- W_CHK:
  - s_ready=0; one cycle.
  - nW = rowsW*colsW.
  - Error if rowsW != colsA, colsW==0, or 3*nW+1 > 2^ADDR_W; on error, pulse err and go to IDLE.
  - Otherwise -> W_DATA.
- W_DATA:
  - s_ready=1; words are written to weight address 1+k, for k = 0..3*nW-1.
  - The last accept -> LAUNCH.
- LAUNCH:
  - dut_valid=1, held until dut_ready is sampled 0 (the engine has left IDLE).
  - Then dut_valid=0 and -> WAIT_DONE.
- WAIT_DONE: when dut_ready is sampled 1, pulse done and go to IDLE.

Rules that apply in every state:
- Words offered while s_ready=0 are not consumed. The producer must hold them, per standard valid/ready rules.
- s_data is passed through unmodified; the loader does no arithmetic on elements.
- Address counters are ADDR_W bits and cannot wrap, because the size checks run before any data phase.
- Error cases leave the header word already written in SRAM. Images are then undefined, and the engine is not launched.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - State goes to IDLE.
  - All outputs are 0: s_ready, busy, input_we, weight_we, dut_valid, done, err, and all addresses and data.
  - Any transfer in flight is dropped.
  - Reset in LAUNCH or WAIT_DONE drops dut_valid on the next edge; the engine is not tracked further.
- Write latency:
  - An accept at edge N produces *_we=1 with the matching addr/data during cycle N+1 (registered outputs). we is 0 otherwise.
  - Back-to-back accepts give back-to-back writes, one per cycle, with no bubbles inside a data phase.
- s_ready is a registered state decode; it does not depend combinationally on s_valid.
- Minimum load time: 2 + nA + 1 + 1 + 3*nW + 1 cycles from start to the first LAUNCH cycle, with s_valid held high throughout.
- Handshake timing:
  - dut_valid rises the cycle after the last weight write is issued.
  - The engine leaves IDLE one edge after it samples dut_valid, so dut_valid is high for at least 2 cycles.
- done and err are exactly one cycle wide, never high together, and are followed by IDLE.
- start arriving in the same cycle as done or err is ignored, because the state is not yet IDLE.
- busy is 1 from the edge after start until the edge after done or err.

## Test plan
- Nominal 4x16 A with 16x16 W, s_valid always high:
  - Expect input writes at addresses 0..64 with header 0x0004_0010.
  - Expect weight writes at addresses 0..768 with header 0x0010_0010.
  - Then dut_valid is held until dut_ready=0; done pulses once dut_ready returns to 1.
- Random s_valid gaps (about 30% idle) on a 2x4 A with 4x4 W:
  - Expect the same SRAM image contents as with no gaps.
  - Expect no write while s_valid=0, and addresses strictly sequential within each phase.
- Dimension mismatch: A header 0x0002_0004, W header 0x0003_0004:
  - Expect an err pulse the cycle after W_CHK, a return to IDLE, and no dut_valid.
  - Expect no weight writes beyond address 0.
- Zero or oversize header: A header 0x0000_0008, then 0xFFFF_FFFF with ADDR_W=16:
  - Each gives err in A_CHK, with only address 0 written.
- Reset mid-stream (during A_DATA at k=5) and reset during WAIT_DONE:
  - The next cycle shows all outputs 0 and state IDLE.
  - A fresh start then reloads a full image from address 0.
- start pulses while busy, and a late dut_ready drop (engine holds dut_ready=1 for 5 cycles after dut_valid):
  - Extra start pulses are ignored.
  - dut_valid stays high all 5 cycles; done is not issued until the engine has gone low and then high again.
